// File: rtl/comp_writeback_if.sv
// Result-stream and DRAM write-request bundle for comp_writeback.
// slave = the write-back block; master = compute stage plus memory side.
interface comp_writeback_if #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 32
);
    logic                  valid_i;
    logic [DATA_WIDTH-1:0] data_i;
    logic                  flag_i;
    logic                  ready_o;
    logic                  mem_req_valid_o;
    logic [ADDR_WIDTH-1:0] mem_req_addr_o;
    logic [DATA_WIDTH-1:0] mem_req_data_o;
    logic                  mem_req_ready_i;

    modport slave (
        input  valid_i, data_i, flag_i, mem_req_ready_i,
        output ready_o, mem_req_valid_o, mem_req_addr_o, mem_req_data_o
    );

    modport master (
        output valid_i, data_i, flag_i, mem_req_ready_i,
        input  ready_o, mem_req_valid_o, mem_req_addr_o, mem_req_data_o
    );
endinterface

// File: rtl/comp_writeback.sv
// Apply-phase write-back: queues flagged vertices as DRAM writes, counts updates, reports convergence.
// Optional WB_PERF_CNT_EN adds stall_cnt_o (cycles with a request waiting on mem_req_ready_i).
module comp_writeback #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
`ifdef WB_PERF_CNT_EN
    output logic [31:0]           stall_cnt_o,
`endif
    input  logic                  start_i,
    input  logic [ADDR_WIDTH-1:0] num_vert_i,
    input  logic [ADDR_WIDTH-1:0] base_addr_i,
    output logic                  done_o,
    output logic                  converged_o,
    output logic [ADDR_WIDTH-1:0] update_cnt_o,
    comp_writeback_if.slave       wb
);
    localparam int BYTE_SHIFT = $clog2(DATA_WIDTH / 8);
    localparam int PTR_W      = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t                state, next_state;
    logic [ADDR_WIDTH-1:0] idx;
    logic [ADDR_WIDTH-1:0] upd_cnt;
    logic [ADDR_WIDTH-1:0] cnt_final;
    logic [ADDR_WIDTH-1:0] num_vert_q;
    logic [ADDR_WIDTH-1:0] base_q;
    logic [PTR_W:0]        wr_ptr, rd_ptr;
    logic [ADDR_WIDTH-1:0] fifo_addr [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] fifo_data [FIFO_DEPTH];
    logic                  fifo_full, fifo_empty;
    logic                  ready_c, beat_acc, push, pop;
    logic                  start_acc, last_beat, enter_done;

    function automatic logic [ADDR_WIDTH-1:0] sat_inc(input logic [ADDR_WIDTH-1:0] v);
        return (&v) ? v : v + ADDR_WIDTH'(1);
    endfunction

    // Byte address of a vertex; the add wraps at the address width.
    function automatic logic [ADDR_WIDTH-1:0] vert_addr(input logic [ADDR_WIDTH-1:0] base,
                                                        input logic [ADDR_WIDTH-1:0] i);
        return base + (i << BYTE_SHIFT);
    endfunction

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                        (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);

    // ready ignores a same-cycle pop so the full FIFO never sees a push
    assign ready_c   = (state == RUN) & ~fifo_full;
    assign beat_acc  = wb.valid_i & ready_c;
    assign push      = beat_acc & wb.flag_i;
    assign pop       = ~fifo_empty & wb.mem_req_ready_i;
    assign start_acc = (state == IDLE) & start_i;
    assign last_beat = (idx == num_vert_q - ADDR_WIDTH'(1));

    always_comb begin
        next_state = state;
        case (state)
            IDLE:  if (start_i) next_state = (num_vert_i == '0) ? DONE : RUN;
            RUN:   if (wb.valid_i && !fifo_full && last_beat) next_state = DRAIN;
            DRAIN: if (fifo_empty) next_state = DONE;
            DONE:  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    assign enter_done = (next_state == DONE) && (state != DONE);
    assign cnt_final  = (state == IDLE) ? '0 : upd_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            idx          <= '0;
            upd_cnt      <= '0;
            update_cnt_o <= '0;
            converged_o  <= 1'b0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
        end else begin
            state <= next_state;
            if (start_acc) begin
                idx     <= '0;
                upd_cnt <= '0;
            end else if (beat_acc) begin
                idx <= idx + ADDR_WIDTH'(1);
                if (wb.flag_i) upd_cnt <= sat_inc(upd_cnt);
            end
            if (enter_done) begin
                update_cnt_o <= cnt_final;
                converged_o  <= (cnt_final == '0);
            end
            if (push) wr_ptr <= wr_ptr + (PTR_W + 1)'(1);
            if (pop)  rd_ptr <= rd_ptr + (PTR_W + 1)'(1);
        end
    end

    // Iteration parameters and queued payloads carry no reset; they are written before use.
    always_ff @(posedge clk) begin
        if (start_acc) begin
            num_vert_q <= num_vert_i;
            base_q     <= base_addr_i;
        end
        if (push) begin
            fifo_addr[wr_ptr[PTR_W-1:0]] <= vert_addr(base_q, idx);
            fifo_data[wr_ptr[PTR_W-1:0]] <= wb.data_i;
        end
    end

    assign wb.ready_o         = ready_c;
    assign wb.mem_req_valid_o = ~fifo_empty;
    assign wb.mem_req_addr_o  = fifo_empty ? '0 : fifo_addr[rd_ptr[PTR_W-1:0]];
    assign wb.mem_req_data_o  = fifo_empty ? '0 : fifo_data[rd_ptr[PTR_W-1:0]];
    assign done_o             = (state == DONE);

`ifdef WB_PERF_CNT_EN
    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (&v) ? v : v + 32'd1;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_o <= '0;
        end else if (start_acc) begin
            stall_cnt_o <= '0;
        end else if (!fifo_empty && !wb.mem_req_ready_i) begin
            stall_cnt_o <= sat_inc32(stall_cnt_o);
        end
    end
`endif
endmodule
